// File: rtl/pulse_gen_if.sv
// Pulse generator control/status bundle: configuration and commands in, pulse and status out.
interface pulse_gen_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8,
    parameter int unsigned P  = 4
);
    logic [W-1:0]  period;
    logic [W-1:0]  width;
    logic [CW-1:0] count;
    logic [P-1:0]  prescale;
    logic          load;
    logic          stop;
    logic          act;
    logic          busy;
    logic          done;

    // Controller side: drives configuration and commands, observes the pulse and status.
    modport master (
        output period, width, count, prescale, load, stop,
        input  act, busy, done
    );

    // Generator side.
    modport slave (
        input  period, width, count, prescale, load, stop,
        output act, busy, done
    );
endinterface

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: single pulses, fixed bursts or continuous PWM trains.
// A prescaler divides the clock into ticks; period and high width are counted in ticks.
module pulse_gen #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8,
    parameter int unsigned P  = 4
) (
    input  logic        clock,
    input  logic        reset,
    pulse_gen_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [W-1:0]  r_period;
    logic [W-1:0]  r_width;
    logic [CW-1:0] r_count;
    logic [P-1:0]  r_prescale;
    logic [P-1:0]  r_pre;
    logic [W-1:0]  r_e;
    logic [CW-1:0] r_rem;
    logic          r_done;

    logic [W-1:0]  w_period_nxt;
    logic [W-1:0]  w_width_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [P-1:0]  w_prescale_nxt;
    logic [P-1:0]  w_pre_nxt;
    logic [W-1:0]  w_e_nxt;
    logic [CW-1:0] w_rem_nxt;
    logic          w_done_nxt;

    logic          w_load_ok;
    logic          w_tick;
    logic          w_period_end;
    logic          w_running;

    // A load with a zero period is dropped entirely, so it cannot disturb a running train.
    assign w_load_ok    = bus.load && (bus.period != '0);
    assign w_tick       = (r_pre == '0);
    assign w_period_end = (r_e == (r_period - W'(1)));
    assign w_running    = (r_state == ST_RUN);

    // State and counter registers; reset clears everything asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_period   <= '0;
            r_width    <= '0;
            r_count    <= '0;
            r_prescale <= '0;
            r_pre      <= '0;
            r_e        <= '0;
            r_rem      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_period   <= w_period_nxt;
            r_width    <= w_width_nxt;
            r_count    <= w_count_nxt;
            r_prescale <= w_prescale_nxt;
            r_pre      <= w_pre_nxt;
            r_e        <= w_e_nxt;
            r_rem      <= w_rem_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state logic: load beats stop, stop beats counting.
    always_comb begin
        w_state_nxt    = r_state;
        w_period_nxt   = r_period;
        w_width_nxt    = r_width;
        w_count_nxt    = r_count;
        w_prescale_nxt = r_prescale;
        w_pre_nxt      = r_pre;
        w_e_nxt        = r_e;
        w_rem_nxt      = r_rem;
        w_done_nxt     = 1'b0;

        if (w_load_ok) begin
            // Restart from any state; an aborted burst never reports done.
            w_period_nxt   = bus.period;
            w_width_nxt    = bus.width;
            w_count_nxt    = bus.count;
            w_prescale_nxt = bus.prescale;
            w_pre_nxt      = bus.prescale;
            w_e_nxt        = '0;
            w_rem_nxt      = bus.count;
            w_state_nxt    = ST_RUN;
        end else if (r_state == ST_RUN) begin
            if (bus.stop) begin
                w_state_nxt = ST_IDLE;
            end else if (!w_tick) begin
                w_pre_nxt = r_pre - P'(1);
            end else begin
                w_pre_nxt = r_prescale;
                if (!w_period_end) begin
                    w_e_nxt = r_e + W'(1);
                end else begin
                    w_e_nxt = '0;
                    // A zero count runs forever and never completes.
                    if (r_count != '0) begin
                        if (r_rem == CW'(1)) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_rem_nxt = r_rem - CW'(1);
                        end
                    end
                end
            end
        end
    end

    // Outputs decoded straight from registers; unsigned compare makes width >= period a constant high.
    assign bus.busy = w_running;
    assign bus.act  = w_running && (r_e < r_width);
    assign bus.done = r_done;

endmodule
